// File: rtl/uart_rx_param.sv
// UART receiver with 3-sample majority voting and a one-word valid/ready holding register; parity bit is enabled by UART_RX_PARITY_EN.
// A word appears 1 cycle after the mid-stop decision; a full holding register (o_valid & ~i_ready) drops the new word and pulses o_overrun.
module uart_rx_param #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 SYS_CLK,
    input  logic                 SYS_RST,
    input  logic                 i_RX,
    input  logic                 i_ready,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_frame_err,
    output logic                 o_parity_err,
    output logic                 o_overrun
);

    localparam int              CNT_W       = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LP_MID_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] LP_MID     = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] LP_MID_P1  = CNT_W'(CLKS_PER_BIT / 2 + 1);
    localparam logic [CNT_W-1:0] LP_LAST    = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       LP_LAST_BIT = 4'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_rx_meta;
    logic                  r_rx_s;
    logic [CNT_W-1:0]      r_cnt;
    logic [3:0]            r_bit_idx;
    logic [1:0]            r_vote;
    logic [DATA_BITS-1:0]  r_shift;
    logic                  w_maj;
    logic                  w_mid_end;
    logic                  w_bit_end;
    logic                  w_shift_en;
    logic                  w_good;
    logic                  w_ferr;
    logic                  w_par_bad;

    assign w_maj     = (r_vote[0] & r_vote[1]) | (r_vote[0] & r_rx_s) | (r_vote[1] & r_rx_s);
    assign w_mid_end = (r_cnt == LP_MID_P1);
    assign w_bit_end = (r_cnt == LP_LAST);

`ifdef UART_RX_PARITY_EN
    logic r_par_bad;
    logic w_par_en;
    logic w_perr;
    assign w_par_bad = r_par_bad;
`else
    assign w_par_bad    = 1'b0;
    assign o_parity_err = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_shift_en  = 1'b0;
        w_good      = 1'b0;
        w_ferr      = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_en    = 1'b0;
        w_perr      = 1'b0;
`endif
        case (r_state)
            S_IDLE: if (!r_rx_s) w_state_nxt = S_START;
            S_START: begin
                if (w_mid_end && w_maj) w_state_nxt = S_IDLE;
                else if (w_bit_end)     w_state_nxt = S_DATA;
            end
            S_DATA: begin
                w_shift_en = w_mid_end;
                if (w_bit_end && r_bit_idx == LP_LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                    w_state_nxt = S_PARITY;
`else
                    w_state_nxt = S_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                w_par_en = w_mid_end;
                if (w_bit_end) w_state_nxt = S_STOP;
            end
`endif
            S_STOP: begin
                // Decide at mid-stop so the next start edge is never missed.
                if (w_mid_end) begin
`ifdef UART_RX_PARITY_EN
                    w_perr = r_par_bad;
`endif
                    if (w_maj) begin
                        w_state_nxt = S_IDLE;
                        w_good      = !w_par_bad;
                    end else begin
                        w_state_nxt = S_WAIT_HIGH;
                        w_ferr      = 1'b1;
                    end
                end
            end
            S_WAIT_HIGH: if (r_rx_s) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge SYS_CLK) begin
        if (SYS_RST) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_ff @(posedge SYS_CLK) begin
        if (SYS_RST) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_vote    <= '0;
            r_shift   <= '0;
        end else begin
            r_rx_meta <= i_RX;
            r_rx_s    <= r_rx_meta;
            if (r_state == S_IDLE || r_state == S_WAIT_HIGH || w_bit_end) r_cnt <= '0;
            else                                                          r_cnt <= r_cnt + 1'b1;
            if (r_state != S_DATA) r_bit_idx <= '0;
            else if (w_bit_end)    r_bit_idx <= r_bit_idx + 4'd1;
            if (r_cnt == LP_MID_M1) r_vote[0] <= r_rx_s;
            if (r_cnt == LP_MID)    r_vote[1] <= r_rx_s;
            if (w_shift_en) r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge SYS_CLK) begin
        if (SYS_RST) begin
            r_par_bad    <= 1'b0;
            o_parity_err <= 1'b0;
        end else begin
            o_parity_err <= w_perr;
            if (r_state == S_IDLE) r_par_bad <= 1'b0;
            else if (w_par_en)     r_par_bad <= (w_maj != ((^r_shift) ^ (PARITY_ODD != 0)));
        end
    end
`endif

    always_ff @(posedge SYS_CLK) begin
        if (SYS_RST) begin
            o_data      <= '0;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            o_frame_err <= w_ferr;
            o_overrun   <= w_good & o_valid & ~i_ready;
            if (w_good && (!o_valid || i_ready)) begin
                o_data  <= r_shift;
                o_valid <= 1'b1;
            end else if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule
